// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// execute_stage : RV32IM execute stage with forwarding, ALU, branch resolution
//                 and an iterative mul/div unit. Option: EXEC_DIV_ZERO_FAST_EN
// Revision      : 1.0
// ============================================================================
module execute_stage #(
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        FlushE,
  input  logic        JumpE,
  input  logic        JalrE,
  input  logic        BranchE,
  input  logic        MulDivE,
  input  logic [2:0]  Funct3E,
  input  logic [3:0]  ALUControlE,
  input  logic        ALUSrcAE,
  input  logic        ALUSrcBE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] rs1_data_E,
  input  logic [31:0] rs2_data_E,
  input  logic [31:0] PCE,
  input  logic [31:0] immExtE,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] ResultW,
  output logic [31:0] ALUResultE,
  output logic [31:0] WriteDataE,
  output logic [31:0] PCTargetE,
  output logic        PCSrcE,
  output logic        StallMD
);

  localparam int         DI      = 32 / DIV_BITS_PER_CYCLE;
  localparam logic [5:0] DI_LAST = 6'(DI - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  md_state_e   state_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [1:0]  f3_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] result_q;
  logic [5:0]  cnt_q;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_res;
  logic        br_cond;

  always_comb begin
    case (ForwardAE)
      2'b01:   fwd_a = ResultW;
      2'b10:   fwd_a = ALUResultM;
      default: fwd_a = rs1_data_E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = rs2_data_E;
    endcase
  end

  assign src_a      = ALUSrcAE ? PCE : fwd_a;
  assign src_b      = ALUSrcBE ? immExtE : fwd_b;
  assign WriteDataE = fwd_b;

  always_comb begin
    alu_res = 32'd0;
    case (ALUControlE)
      4'd0:    alu_res = src_a + src_b;
      4'd1:    alu_res = src_a - src_b;
      4'd2:    alu_res = src_a & src_b;
      4'd3:    alu_res = src_a | src_b;
      4'd4:    alu_res = src_a ^ src_b;
      4'd5:    alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
      4'd6:    alu_res = {31'd0, src_a < src_b};
      4'd7:    alu_res = src_a << src_b[4:0];
      4'd8:    alu_res = src_a >> src_b[4:0];
      4'd9:    alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
      4'd10:   alu_res = src_b;
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (Funct3E)
      3'b000:  br_cond = (fwd_a == fwd_b);
      3'b001:  br_cond = (fwd_a != fwd_b);
      3'b100:  br_cond = ($signed(fwd_a) < $signed(fwd_b));
      3'b101:  br_cond = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110:  br_cond = (fwd_a < fwd_b);
      3'b111:  br_cond = (fwd_a >= fwd_b);
      default: br_cond = 1'b0;
    endcase
  end

  // rst_n gates the stall so an asynchronous reset releases the pipeline at once
  assign StallMD = rst_n & ~FlushE &
                   (((state_q == S_IDLE) & MulDivE) | (state_q == S_MUL) | (state_q == S_DIV));

  assign PCSrcE     = (JumpE | (BranchE & br_cond)) & ~StallMD;
  assign PCTargetE  = JalrE ? ((fwd_a + immExtE) & ~32'd1) : (PCE + immExtE);
  assign ALUResultE = (state_q == S_DONE) ? result_q : alu_res;

  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_p;
  logic [31:0] mul_res;

  // Sign-extending to 64 bits makes the truncated product exact for every mode
  assign mul_a   = {{32{(f3_q != 2'b11) & opa_q[31]}}, opa_q};
  assign mul_b   = {{32{~f3_q[1] & opb_q[31]}}, opb_q};
  assign mul_p   = mul_a * mul_b;
  assign mul_res = (f3_q == 2'b00) ? mul_p[31:0] : mul_p[63:32];

  logic        div_signed;
  logic [31:0] dvsr_mag;
  logic [31:0] dvnd_mag_in;
  logic [31:0] div_rem_d;
  logic [31:0] div_quo_d;
  logic [32:0] div_sh;
  logic [32:0] div_df;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;
  logic [31:0] div_res;

  assign div_signed  = ~f3_q[0];
  assign dvsr_mag    = (div_signed & opb_q[31]) ? -opb_q : opb_q;
  assign dvnd_mag_in = (~Funct3E[0] & fwd_a[31]) ? -fwd_a : fwd_a;

  always_comb begin
    div_rem_d = rem_q;
    div_quo_d = quo_q;
    div_sh    = 33'd0;
    div_df    = 33'd0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      div_sh    = {div_rem_d, div_quo_d[31]};
      div_quo_d = {div_quo_d[30:0], 1'b0};
      div_df    = div_sh - {1'b0, dvsr_mag};
      if (!div_df[32]) begin
        div_rem_d    = div_df[31:0];
        div_quo_d[0] = 1'b1;
      end else begin
        div_rem_d = div_sh[31:0];
      end
    end
  end

  // Zero divisor bypasses sign correction so the remainder is the raw dividend
  always_comb begin
    if (opb_q == 32'd0) begin
      quo_fin = 32'hFFFF_FFFF;
      rem_fin = opa_q;
    end else begin
      quo_fin = (div_signed & (opa_q[31] ^ opb_q[31])) ? -div_quo_d : div_quo_d;
      rem_fin = (div_signed & opa_q[31]) ? -div_rem_d : div_rem_d;
    end
    div_res = f3_q[1] ? rem_fin : quo_fin;
  end

  logic        dz_fast;
  logic [31:0] dz_res;

`ifdef EXEC_DIV_ZERO_FAST_EN
  assign dz_fast = (fwd_b == 32'd0);
  assign dz_res  = Funct3E[1] ? fwd_a : 32'hFFFF_FFFF;
`else
  assign dz_fast = 1'b0;
  assign dz_res  = 32'hFFFF_FFFF;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      f3_q     <= 2'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      result_q <= 32'd0;
      cnt_q    <= 6'd0;
    end else if (FlushE) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (MulDivE) begin
            opa_q <= fwd_a;
            opb_q <= fwd_b;
            f3_q  <= Funct3E[1:0];
            rem_q <= 32'd0;
            quo_q <= dvnd_mag_in;
            cnt_q <= 6'd0;
            if (!Funct3E[2]) begin
              state_q <= S_MUL;
            end else if (dz_fast) begin
              result_q <= dz_res;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          result_q <= mul_res;
          state_q  <= S_DONE;
        end
        S_DIV: begin
          rem_q <= div_rem_d;
          quo_q <= div_quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == DI_LAST) begin
            result_q <= div_res;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// tb_execute_stage : randomized self-checking bench for execute_stage against
//                    an arithmetic reference model
// Revision         : 1.0
// ============================================================================
module tb_execute_stage;

  localparam int BPC = 1;
  localparam int DI  = 32 / BPC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FlushE, JumpE, JalrE, BranchE, MulDivE;
  logic [2:0]  Funct3E;
  logic [3:0]  ALUControlE;
  logic        ALUSrcAE, ALUSrcBE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] rs1_data_E, rs2_data_E, PCE, immExtE, ALUResultM, ResultW;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE;
  logic        PCSrcE, StallMD;

  always #5 clk = ~clk;

  execute_stage #(.DIV_BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .FlushE(FlushE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .MulDivE(MulDivE), .Funct3E(Funct3E),
    .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .rs1_data_E(rs1_data_E),
    .rs2_data_E(rs2_data_E), .PCE(PCE), .immExtE(immExtE),
    .ALUResultM(ALUResultM), .ResultW(ResultW), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .PCTargetE(PCTargetE), .PCSrcE(PCSrcE),
    .StallMD(StallMD)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] reg_v,
                                          input logic [31:0] m, input logic [31:0] w);
    if (sel == 2'b01) return w;
    if (sel == 2'b10) return m;
    return reg_v;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb, sh;
    sa = a; sb = b; sh = int'(b % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return 32'(sa >>> sh);
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a; sb = b;
    case (f3)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    logic [31:0] q, r;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return 32'(p); end
      3'd1: begin p = sa * sb; return 32'(p >> 32); end
      3'd2: begin p = sa * ub; return 32'(p >> 32); end
      3'd3: begin p = ua * ub; return 32'(p >> 32); end
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF; r = a;
        end else if (f3[0]) begin
          q = a / b; r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          q = a; r = 32'd0;
        end else begin
          ia = a; ib = b;
          q = ia / ib; r = ia % ib;
        end
        return f3[1] ? r : q;
      end
    endcase
  endfunction

  function automatic int exp_stalls(input logic [2:0] f3, input logic [31:0] b);
    if (!f3[2]) return 2;
`ifdef EXEC_DIV_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return DI + 1;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    FlushE = 0; JumpE = 0; JalrE = 0; BranchE = 0; MulDivE = 0;
    Funct3E = 0; ALUControlE = 0; ALUSrcAE = 0; ALUSrcBE = 0;
    ForwardAE = 0; ForwardBE = 0;
    rs1_data_E = 0; rs2_data_E = 0; PCE = 0; immExtE = 0; ALUResultM = 0; ResultW = 0;
  endtask

  task automatic start_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input bit via_fwd);
    idle_inputs();
    MulDivE = 1; Funct3E = f3; JumpE = 1;
    if (via_fwd) begin
      ForwardAE = 2'b10; ALUResultM = a; rs1_data_E = $urandom;
      ForwardBE = 2'b01; ResultW = b;    rs2_data_E = $urandom;
    end else begin
      rs1_data_E = a; rs2_data_E = b;
    end
  endtask

  task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit via_fwd);
    int stalls;
    next_cycle();
    start_md(f3, a, b, via_fwd);
    #3;
    check({tag, "_stall0"}, {31'd0, StallMD}, 32'd1);
    check({tag, "_pcsrc_held"}, {31'd0, PCSrcE}, 32'd0);
    stalls = 0;
    while (StallMD === 1'b1 && stalls < 200) begin
      stalls++;
      next_cycle();
      ALUResultM = $urandom;
      ResultW    = $urandom;
      #3;
    end
    check({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls(f3, b)));
    check({tag, "_result"}, ALUResultE, ref_md(f3, a, b));
    next_cycle();
    idle_inputs();
  endtask

  logic [31:0] fa, fb, sa, sb;

  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    check("rst_stall", {31'd0, StallMD}, 32'd0);
    check("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
    check("rst_alu", ALUResultE, 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1;

    // forwarded ADD
    next_cycle();
    ForwardAE = 2'b10; ALUResultM = 5; ForwardBE = 2'b01; ResultW = 7;
    rs1_data_E = 100; rs2_data_E = 200;
    #3;
    check("fwd_add", ALUResultE, 32'd12);
    check("fwd_add_stall", {31'd0, StallMD}, 32'd0);

    // BLT taken, BLTU not taken
    next_cycle();
    idle_inputs();
    rs1_data_E = 32'hFFFF_FFFF; rs2_data_E = 1; immExtE = 32'hFFFF_FFF8; PCE = 32'h100;
    BranchE = 1; Funct3E = 3'b100;
    #3;
    check("blt_pcsrc", {31'd0, PCSrcE}, 32'd1);
    check("blt_target", PCTargetE, 32'hF8);
    Funct3E = 3'b110;
    #1;
    check("bltu_pcsrc", {31'd0, PCSrcE}, 32'd0);

    // random ALU / branch / jump traffic
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      idle_inputs();
      ALUControlE = 4'($urandom_range(0, 15));
      Funct3E = 3'($urandom_range(0, 7));
      JumpE = 1'($urandom_range(0, 3) == 0);
      JalrE = 1'($urandom);
      BranchE = 1'($urandom);
      ALUSrcAE = 1'($urandom); ALUSrcBE = 1'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      rs1_data_E = rnd32(); rs2_data_E = rnd32(); PCE = $urandom; immExtE = rnd32();
      ALUResultM = rnd32(); ResultW = rnd32();
      fa = ref_fwd(ForwardAE, rs1_data_E, ALUResultM, ResultW);
      fb = ref_fwd(ForwardBE, rs2_data_E, ALUResultM, ResultW);
      sa = ALUSrcAE ? PCE : fa;
      sb = ALUSrcBE ? immExtE : fb;
      #3;
      check("rnd_alu", ALUResultE, ref_alu(ALUControlE, sa, sb));
      check("rnd_wdata", WriteDataE, fb);
      check("rnd_pcsrc", {31'd0, PCSrcE}, {31'd0, JumpE | (BranchE & ref_br(Funct3E, fa, fb))});
      check("rnd_target", PCTargetE, JalrE ? ((fa + immExtE) & ~32'd1) : (PCE + immExtE));
      check("rnd_stall", {31'd0, StallMD}, 32'd0);
    end

    // directed mul/div cases
    run_md("mulh",   3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    run_md("mulhu",  3'd3, 32'hFFFF_FFFF, 32'd2, 1);
    run_md("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_md("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 1);
    run_md("div_ov", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md("divu_0", 3'd5, 32'd9, 32'd0, 0);
    run_md("rem_0",  3'd6, 32'hFFFF_FFF7, 32'd0, 1);

    // random mul/div
    for (int i = 0; i < 24; i++) begin
      run_md("rnd_md", 3'($urandom_range(0, 7)), rnd32(), rnd32(), 1'($urandom));
    end

    // flush in the middle of a divide
    next_cycle();
    start_md(3'd4, 32'd100, 32'd7, 0);
    for (int i = 0; i < 10; i++) next_cycle();
    check("pre_flush_busy", {31'd0, StallMD}, 32'd1);
    FlushE = 1;
    #1;
    check("flush_comb", {31'd0, StallMD}, 32'd0);
    next_cycle();
    idle_inputs();
    rs1_data_E = 3; rs2_data_E = 4;
    #3;
    check("flush_idle", {31'd0, StallMD}, 32'd0);
    check("flush_add", ALUResultE, 32'd7);
    next_cycle();
    #3;
    check("flush_idle2", {31'd0, StallMD}, 32'd0);

    // asynchronous reset in the middle of a divide
    next_cycle();
    start_md(3'd5, 32'd1000, 32'd3, 0);
    for (int i = 0; i < 5; i++) next_cycle();
    rst_n = 0;
    #1;
    check("rst_async", {31'd0, StallMD}, 32'd0);
    next_cycle();
    idle_inputs();
    next_cycle();
    rst_n = 1;
    #3;
    check("rst_idle", {31'd0, StallMD}, 32'd0);
    run_md("post_rst_mul", 3'd0, 32'd12345, 32'hFFFF_FFFD, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the 5-stage RV32IM pipeline. It consumes the decode/execute pipeline register outputs and produces the ALU result, store data, branch/jump redirect and target for the execute/memory register.
- Contains operand forwarding muxes, the RV32I ALU, branch resolution and an iterative multiply/divide unit (FSM).
- The multiply/divide unit stalls the front of the pipeline while busy.

Parameters:
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per divide cycle. Legal values 1, 2, 4. Divide iterations DI = 32/DIV_BITS_PER_CYCLE.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- FlushE  in  1  kill the instruction in E; aborts any mul/div in progress
- JumpE  in  1  JAL/JALR
- JalrE  in  1  JALR (target from rs1)
- BranchE  in  1  conditional branch
- MulDivE  in  1  M-extension op; Funct3E selects the operation
- Funct3E  in  3  branch condition / M op
- ALUControlE  in  4  ALU op
- ALUSrcAE  in  1  0: forwarded rs1, 1: PCE
- ALUSrcBE  in  1  0: forwarded rs2, 1: immExtE
- ForwardAE, ForwardBE  in  2 each  00: register data, 01: ResultW, 10: ALUResultM, 11: register data
- rs1_data_E, rs2_data_E, PCE, immExtE  in  32 each  operands from DE register
- ALUResultM, ResultW  in  32 each  forwarding sources
- ALUResultE  out  32  result to EM register
- WriteDataE  out  32  forwarded rs2 (store data)
- PCTargetE  out  32  redirect target
- PCSrcE  out  1  take redirect
- StallMD  out  1  hold F, D and DE registers; bubble the EM register

Behaviour:
- Forwarding and ALU are combinational.
  - SrcA = ALUSrcAE ? PCE : fwdA.
  - SrcB = ALUSrcBE ? immExtE : fwdB.
  - WriteDataE = fwdB.
- ALUControlE encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLT, 6 SLTU
  - 7 SLL, 8 SRL, 9 SRA (shift amount = SrcB[4:0])
  - 10 PASS SrcB
  - 11-15 give result 0
- Branch condition on fwdA vs fwdB, by Funct3E:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU
  - 010 and 011 are never taken.
- PCSrcE = JumpE | (BranchE & cond). PCSrcE is forced to 0 while StallMD=1.
- PCTargetE = JalrE ? ((fwdA+immExtE) & ~1) : (PCE+immExtE).
- ALUResultE is the ALU result when MulDivE=0, and the mul/div result register in state DONE.
- Mul/div FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE; all FSM registers reset to 0.
  - IDLE: if MulDivE & !FlushE, assert StallMD and capture fwdA, fwdB and Funct3E. Go to MUL for Funct3E[2]=0, otherwise go to DIV.
  - MUL: registers the 64-bit signed/unsigned product. MUL returns the low word; MULH, MULHSU and MULHU return the high word. Go to DONE.
  - DIV: unsigned restoring divide on operand magnitudes, DIV_BITS_PER_CYCLE bits per cycle, for DI cycles. Then sign-correct: quotient negated if the operand signs differ, remainder takes the dividend's sign. Go to DONE.
  - DONE: StallMD=0 and the result drives ALUResultE. Go to IDLE unconditionally; an op is never restarted from DONE.
- StallMD = (IDLE & MulDivE & !FlushE) | MUL | DIV.
- Latency:
  - MUL: result in the 3rd E cycle (2 stall cycles).
  - DIV: DI+1 stall cycles. With the default parameter the result is in cycle 33, counting from 0.
- Special cases:
  - DIV 0x80000000 / -1 gives quotient 0x80000000, remainder 0.
  - x/0 gives quotient 0xFFFFFFFF and remainder = dividend, for both signed and unsigned.
- FlushE in any state returns the FSM to IDLE next cycle and deasserts StallMD combinationally.
- Reset mid-operation aborts immediately: StallMD=0, FSM in IDLE.
- Operands are captured at start, so changes on M/W forwarding paths during a stall do not affect the result.

Optional Feature:
- EXEC_DIV_ZERO_FAST_EN
  - Defined: a DIV-class op with a zero divisor skips DIV and goes IDLE→DONE with the defined results (1 stall cycle).
  - Undefined: it runs the full DI iterations; the sign correction is suppressed for a zero divisor. Results are identical and only latency differs.

Test Plan:
- ADD, ForwardAE=10 with ALUResultM=5, ForwardBE=01 with ResultW=7 -> ALUResultE=12, StallMD=0.
- BLT, fwdA=0xFFFFFFFF, fwdB=1, immExtE=-8, PCE=0x100 -> PCSrcE=1, PCTargetE=0xF8. Same operands with BLTU -> PCSrcE=0.
- MULH 0xFFFFFFFF×2 -> StallMD high 2 cycles, then ALUResultE=0xFFFFFFFF. MULHU with the same operands -> 0x00000001.
- DIV -7/2 -> 33 stall cycles, then result -3. REM with the same operands -> -1. DIV 0x80000000/-1 -> 0x80000000.
- DIVU 9/0 -> 0xFFFFFFFF; REM -9/0 -> -9. Stall is 1 cycle with EXEC_DIV_ZERO_FAST_EN, 33 cycles without.
- FlushE at cycle 10 of a DIV -> StallMD=0 immediately, FSM IDLE; a following ADD completes normally. rst_n low mid-DIV -> StallMD=0 asynchronously.
